// File: rtl/alu_wb_collector.sv
// Write-back collector between the vector-lane ALU and the VRF write arbiter.
// It forwards element results or packs compare bits into mask words, buffered in a small FIFO.
module alu_wb_collector #(
  parameter int OP_WIDTH        = 32,
  parameter int PARALLEL_IF_NUM = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int STALL_MARGIN    = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic                                mask_mode_i,
  input  logic [15:0]                         beat_num_i,
  input  logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] alu_o_i,
  input  logic [PARALLEL_IF_NUM-1:0]          alu_vld_i,
  input  logic [PARALLEL_IF_NUM-1:0]          alu_mask_vector_i,
  output logic                                alu_stall_o,
  output logic [PARALLEL_IF_NUM*OP_WIDTH-1:0] wb_data_o,
  output logic [PARALLEL_IF_NUM-1:0]          wb_we_o,
  output logic                                wb_mask_o,
  output logic                                wb_vld_o,
  input  logic                                wb_rdy_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                overflow_o
);

  localparam int DATA_W  = PARALLEL_IF_NUM * OP_WIDTH;
  localparam int ENTRY_W = DATA_W + PARALLEL_IF_NUM + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int P_W     = $clog2(OP_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                     state_r;
  logic [15:0]                beat_cnt_r;
  logic [15:0]                beat_num_r;
  logic                       mask_mode_r;
  logic [P_W-1:0]             p_r;
  logic [OP_WIDTH-1:0]        word_r;
  logic                       done_r;
  logic                       overflow_r;
  logic [ENTRY_W-1:0]         mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [CNT_W-1:0]           count_r;

  logic                       beat_s;
  logic                       last_beat_s;
  logic                       wrap_s;
  logic [P_W-1:0]             p_next_s;
  logic [OP_WIDTH-1:0]        word_next_s;
  logic                       push_s;
  logic [DATA_W-1:0]          push_data_s;
  logic [PARALLEL_IF_NUM-1:0] push_we_s;
  logic                       push_mask_s;
  logic                       pop_s;
  logic                       full_s;
  logic                       accept_s;
  logic                       drop_s;
  logic                       head_vld_s;
  logic [ENTRY_W-1:0]         head_s;

  assign beat_s      = (state_r == ST_RUN) && (|alu_vld_i);
  assign last_beat_s = beat_s && (beat_cnt_r == (beat_num_r - 16'd1));
  assign wrap_s      = (p_r == P_W'(OP_WIDTH - PARALLEL_IF_NUM));
  assign p_next_s    = wrap_s ? {P_W{1'b0}} : (p_r + P_W'(PARALLEL_IF_NUM));

  assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
  assign head_vld_s  = (count_r != {CNT_W{1'b0}});
  assign pop_s       = head_vld_s && wb_rdy_i;
  // A push into a full FIFO only survives if the head leaves in the same cycle.
  assign accept_s    = push_s && (!full_s || pop_s);
  assign drop_s      = push_s && full_s && !pop_s;

  // Merge this beat's qualified compare bits into the mask word at the bit pointer.
  always_comb begin
    word_next_s = word_r;
    for (int i = 0; i < PARALLEL_IF_NUM; i++) begin
      word_next_s[p_r + P_W'(i)] = alu_mask_vector_i[i] & alu_vld_i[i];
    end
  end

  // Select what, if anything, enters the FIFO this cycle.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = '0;
    push_we_s   = '0;
    push_mask_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (beat_s && !mask_mode_r) begin
          push_s      = 1'b1;
          push_data_s = alu_o_i;
          push_we_s   = alu_vld_i;
        end else if (beat_s && wrap_s) begin
          push_s                    = 1'b1;
          push_data_s[OP_WIDTH-1:0] = word_next_s;
          push_we_s                 = {{(PARALLEL_IF_NUM-1){1'b0}}, 1'b1};
          push_mask_s               = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        // The partial word waits for room rather than being dropped.
        if (!full_s) begin
          push_s                    = 1'b1;
          push_data_s[OP_WIDTH-1:0] = word_r;
          push_we_s                 = {{(PARALLEL_IF_NUM-1){1'b0}}, 1'b1};
          push_mask_s               = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Instruction sequencing: beat counting, mask packing and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= 16'd0;
      beat_num_r  <= 16'd0;
      mask_mode_r <= 1'b0;
      p_r         <= {P_W{1'b0}};
      word_r      <= {OP_WIDTH{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            beat_cnt_r  <= 16'd0;
            beat_num_r  <= beat_num_i;
            mask_mode_r <= mask_mode_i;
            p_r         <= {P_W{1'b0}};
            word_r      <= {OP_WIDTH{1'b0}};
            if (beat_num_i != 16'd0) begin
              state_r <= ST_RUN;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 16'd1;
            if (mask_mode_r) begin
              word_r <= wrap_s ? {OP_WIDTH{1'b0}} : word_next_s;
              p_r    <= p_next_s;
            end
            if (last_beat_s) begin
              state_r <= (mask_mode_r && !wrap_s) ? ST_FLUSH : ST_DRAIN;
            end
          end
        end
        ST_FLUSH: begin
          if (!full_s) begin
            word_r  <= {OP_WIDTH{1'b0}};
            p_r     <= {P_W{1'b0}};
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!head_vld_s) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // FIFO storage; an entry is written only when the push is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else if (accept_s) begin
      mem_r[wr_ptr_r] <= {push_mask_s, push_we_s, push_data_s};
    end
  end

  // Head is read straight from storage and blanked while the FIFO is empty.
  assign head_s      = head_vld_s ? mem_r[rd_ptr_r] : {ENTRY_W{1'b0}};
  assign wb_data_o   = head_s[DATA_W-1:0];
  assign wb_we_o     = head_s[DATA_W +: PARALLEL_IF_NUM];
  assign wb_mask_o   = head_s[ENTRY_W-1];
  assign wb_vld_o    = head_vld_s;
  assign alu_stall_o = (count_r >= CNT_W'(FIFO_DEPTH - STALL_MARGIN));
  assign busy_o      = (state_r != ST_IDLE);
  assign done_o      = done_r;
  assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_alu_wb_collector.sv
// Self-checking bench for alu_wb_collector: directed corner cases plus randomized
// instructions scored against an instruction-level model of the expected write-back stream.
module tb_alu_wb_collector;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int DW = W * N;

  typedef struct {
    logic [DW-1:0] data;
    logic [N-1:0]  we;
    logic          msk;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          mask_mode_i;
  logic [15:0]   beat_num_i;
  logic [DW-1:0] alu_o_i;
  logic [N-1:0]  alu_vld_i;
  logic [N-1:0]  alu_mask_vector_i;
  logic          alu_stall_o;
  logic [DW-1:0] wb_data_o;
  logic [N-1:0]  wb_we_o;
  logic          wb_mask_o;
  logic          wb_vld_o;
  logic          wb_rdy_i;
  logic          busy_o;
  logic          done_o;
  logic          overflow_o;

  entry_t        exp_q[$];
  entry_t        mon_e;
  logic [N-1:0]  bt_vld[$];
  logic [N-1:0]  bt_mask[$];
  logic [DW-1:0] bt_data[$];
  logic [DW-1:0] dv[5];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  bit            sb_en     = 1'b0;
  bit            rdy_rand  = 1'b0;

  always #5 clk = ~clk;

  alu_wb_collector #(
    .OP_WIDTH(W), .PARALLEL_IF_NUM(N), .FIFO_DEPTH(4), .STALL_MARGIN(2)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mask_mode_i(mask_mode_i),
    .beat_num_i(beat_num_i), .alu_o_i(alu_o_i), .alu_vld_i(alu_vld_i),
    .alu_mask_vector_i(alu_mask_vector_i), .alu_stall_o(alu_stall_o),
    .wb_data_o(wb_data_o), .wb_we_o(wb_we_o), .wb_mask_o(wb_mask_o),
    .wb_vld_o(wb_vld_o), .wb_rdy_i(wb_rdy_i), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    rnd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) wb_rdy_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic reset_dut();
    rst = 1'b1; start_i = 1'b0; mask_mode_i = 1'b0; beat_num_i = 16'd0;
    alu_o_i = '0; alu_vld_i = '0; alu_mask_vector_i = '0;
    wb_rdy_i = 1'b0; rdy_rand = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_data"},     wb_data_o, '0);
    check_eq({tag, "_we"},       DW'(wb_we_o), '0);
    check_eq({tag, "_mask"},     DW'(wb_mask_o), '0);
    check_eq({tag, "_vld"},      DW'(wb_vld_o), '0);
    check_eq({tag, "_stall"},    DW'(alu_stall_o), '0);
    check_eq({tag, "_busy"},     DW'(busy_o), '0);
    check_eq({tag, "_done"},     DW'(done_o), '0);
    check_eq({tag, "_overflow"}, DW'(overflow_o), '0);
  endtask

  // Scoreboard: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (sb_en && !rst && wb_vld_o && wb_rdy_i) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_entry", DW'(exp_q.size()), DW'(1));
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_data", wb_data_o, mon_e.data);
        check_eq("sb_we", DW'(wb_we_o), DW'(mon_e.we));
        check_eq("sb_maskflag", DW'(wb_mask_o), DW'(mon_e.msk));
      end
    end
  end

  task automatic gen_beats(input int n, input bit fixed_full);
    bt_vld.delete(); bt_mask.delete(); bt_data.delete();
    for (int k = 0; k < n; k++) begin
      bt_vld.push_back(fixed_full ? 4'hF : 4'($urandom_range(1, 15)));
      bt_mask.push_back(4'($urandom()));
      bt_data.push_back(rnd_data());
    end
  endtask

  // Reference: data mode is one entry per beat; mask mode is the beat bit stream cut into words.
  task automatic model_push(input bit mm);
    entry_t e;
    int total, nwords, idx;
    if (!mm) begin
      for (int k = 0; k < bt_vld.size(); k++) begin
        e.data = bt_data[k]; e.we = bt_vld[k]; e.msk = 1'b0;
        exp_q.push_back(e);
      end
    end else begin
      total  = bt_vld.size() * N;
      nwords = (total + W - 1) / W;
      for (int w = 0; w < nwords; w++) begin
        e.data = '0; e.we = 4'b0001; e.msk = 1'b1;
        for (int b = 0; b < W; b++) begin
          idx = w * W + b;
          if (idx < total) e.data[b] = bt_mask[idx / N][idx % N] & bt_vld[idx / N][idx % N];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
      end else begin
        tick();
        cyc++;
        alu_vld_i = 4'($urandom()); alu_mask_vector_i = 4'($urandom()); alu_o_i = rnd_data();
        start_i = busy_o && ($urandom_range(0, 3) == 0);
        beat_num_i = 16'($urandom());
      end
    end
    start_i = 1'b0; alu_vld_i = '0;
    check_eq({tag, "_done_seen"}, DW'(seen), DW'(1));
    check_eq({tag, "_drained"}, DW'(exp_q.size()), '0);
    check_eq({tag, "_idle"}, DW'(busy_o), '0);
    tick();
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, DW'(done_o), '0);
  endtask

  task automatic run_instr(input bit mm, input bit use_model, input string tag);
    int n = bt_vld.size();
    int k = 0;
    int budget = 0;
    if (use_model) model_push(mm);
    tick();
    start_i = 1'b1; mask_mode_i = mm; beat_num_i = 16'(n); alu_vld_i = '0;
    tick();
    start_i = 1'b0;
    while (k < n && budget < 4000) begin
      if (!alu_stall_o && ($urandom_range(0, 3) != 0)) begin
        alu_vld_i = bt_vld[k]; alu_mask_vector_i = bt_mask[k]; alu_o_i = bt_data[k];
        k++;
      end else begin
        alu_vld_i = '0; alu_mask_vector_i = 4'($urandom()); alu_o_i = rnd_data();
      end
      start_i = ($urandom_range(0, 7) == 0);
      beat_num_i = 16'($urandom());
      tick();
      budget++;
    end
    check_eq({tag, "_beats_sent"}, DW'(k), DW'(n));
    wait_done(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nv;
    entry_t e;

    reset_dut();
    check_zero("reset");

    // Minimum instruction timing: one data beat, done in cycle 4.
    sb_en = 1'b0;
    tick();
    start_i = 1'b1; beat_num_i = 16'd1; mask_mode_i = 1'b0; wb_rdy_i = 1'b1;
    dv[0] = rnd_data();
    @(negedge clk); check_eq("min_c0_busy", DW'(busy_o), '0);
    tick(); start_i = 1'b0; alu_vld_i = 4'hF; alu_o_i = dv[0];
    @(negedge clk); check_eq("min_c1_busy", DW'(busy_o), DW'(1));
    check_eq("min_c1_vld", DW'(wb_vld_o), '0);
    tick(); alu_vld_i = '0;
    @(negedge clk); check_eq("min_c2_vld", DW'(wb_vld_o), DW'(1));
    check_eq("min_c2_data", wb_data_o, dv[0]);
    check_eq("min_c2_we", DW'(wb_we_o), DW'(4'hF));
    check_eq("min_c2_mask", DW'(wb_mask_o), '0);
    tick();
    @(negedge clk); check_eq("min_c3_vld", DW'(wb_vld_o), '0);
    check_eq("min_c3_done", DW'(done_o), '0);
    tick();
    @(negedge clk); check_eq("min_c4_done", DW'(done_o), DW'(1));
    check_eq("min_c4_busy", DW'(busy_o), '0);
    tick();
    @(negedge clk); check_eq("min_c5_done", DW'(done_o), '0);

    // Zero-beat instruction completes immediately.
    tick(); start_i = 1'b1; beat_num_i = 16'd0; mask_mode_i = 1'($urandom());
    tick(); start_i = 1'b0;
    @(negedge clk); check_eq("zero_done", DW'(done_o), DW'(1));
    check_eq("zero_busy", DW'(busy_o), '0);
    tick();
    @(negedge clk); check_eq("zero_done_pulse", DW'(done_o), '0);

    sb_en = 1'b1;
    wb_rdy_i = 1'b1;
    gen_beats(3, 1'b1);
    run_instr(1'b0, 1'b1, "data3");
    check_eq("data3_overflow", DW'(overflow_o), '0);

    // Mask mode, eight beats of alternating compare bits -> one full word, no flush.
    gen_beats(8, 1'b1);
    for (int k = 0; k < 8; k++) bt_mask[k] = 4'b0101;
    e.data = DW'(32'h5555_5555); e.we = 4'b0001; e.msk = 1'b1;
    exp_q.push_back(e);
    run_instr(1'b1, 1'b0, "mask8");

    // Mask mode, short last beat -> partial word flushed.
    gen_beats(3, 1'b1);
    for (int k = 0; k < 3; k++) bt_mask[k] = 4'hF;
    bt_vld[2] = 4'b0011;
    e.data = DW'(32'h0000_03FF); e.we = 4'b0001; e.msk = 1'b1;
    exp_q.push_back(e);
    run_instr(1'b1, 1'b0, "mask3");

    rdy_rand = 1'b1;
    for (int t = 0; t < 30; t++) begin
      bit mm;
      mm = 1'($urandom());
      gen_beats(mm ? $urandom_range(1, 20) : $urandom_range(1, 10), 1'b0);
      run_instr(mm, 1'b1, mm ? "rand_mask" : "rand_data");
    end
    check_eq("rand_overflow", DW'(overflow_o), '0);

    // Back-pressure: five beats into a stalled depth-4 FIFO, the fifth is dropped.
    reset_dut();
    for (int k = 0; k < 5; k++) dv[k] = rnd_data();
    for (int k = 0; k < 4; k++) begin
      e.data = dv[k]; e.we = 4'hF; e.msk = 1'b0;
      exp_q.push_back(e);
    end
    tick(); start_i = 1'b1; beat_num_i = 16'd5; mask_mode_i = 1'b0;
    tick(); start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      alu_vld_i = 4'hF; alu_o_i = dv[k];
      @(negedge clk);
      check_eq("bp_stall", DW'(alu_stall_o), DW'(k >= 2));
      check_eq("bp_overflow_early", DW'(overflow_o), '0);
      if (k >= 1) check_eq("bp_head_hold", wb_data_o, dv[0]);
      tick();
    end
    alu_vld_i = '0;
    @(negedge clk);
    check_eq("bp_overflow", DW'(overflow_o), DW'(1));
    check_eq("bp_head_final", wb_data_o, dv[0]);
    check_eq("bp_stall_full", DW'(alu_stall_o), DW'(1));
    tick(); wb_rdy_i = 1'b1;
    wait_done("bp");
    check_eq("bp_overflow_sticky", DW'(overflow_o), DW'(1));

    // Full FIFO with push and pop in the same cycle: nothing is lost.
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      dv[k] = rnd_data();
      e.data = dv[k]; e.we = 4'hF; e.msk = 1'b0;
      exp_q.push_back(e);
    end
    tick(); start_i = 1'b1; beat_num_i = 16'd5; mask_mode_i = 1'b0;
    tick(); start_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      alu_vld_i = 4'hF; alu_o_i = dv[k];
      if (k == 4) wb_rdy_i = 1'b1;
      @(negedge clk);
      if (k == 4) check_eq("pp_full_stall", DW'(alu_stall_o), DW'(1));
      tick();
    end
    alu_vld_i = '0;
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_vld_o) nv++;
      tick();
    end
    check_eq("pp_occupancy", DW'(nv), DW'(4));
    check_eq("pp_overflow", DW'(overflow_o), '0);
    wait_done("pp");

    // Reset in the middle of an instruction.
    reset_dut();
    sb_en = 1'b0;
    tick(); start_i = 1'b1; beat_num_i = 16'd5; mask_mode_i = 1'b0;
    tick(); start_i = 1'b0; alu_vld_i = 4'hF; alu_o_i = rnd_data();
    tick(); alu_o_i = rnd_data();
    tick();
    check_eq("rstmid_pre_vld", DW'(wb_vld_o), DW'(1));
    #2 rst = 1'b1;
    #1 check_zero("rstmid");
    alu_vld_i = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      tick();
      @(negedge clk);
      check_eq("rstmid_no_done", DW'(done_o), '0);
    end
    sb_en = 1'b1;
    wb_rdy_i = 1'b1;
    gen_beats(4, 1'b0);
    run_instr(1'b0, 1'b1, "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
